// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: AXI-Stream FIFO with a registered output stage,
// fill-level flags and an optional store-and-forward packet mode.
module axis_fifo_pkt #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 11,
    parameter bit PACKET_MODE = 1'b0,
    parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 16,
    parameter int AE_THRESH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] input_tdata,
    input  logic                  input_tvalid,
    output logic                  input_tready,
    input  logic                  input_tlast,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic                  output_last,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [ADDR_WIDTH-1:0] PONE_C = ADDR_WIDTH'(1);

    typedef enum logic {GATED, FORCED} state_e;

    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CW-1:0]         mem_cnt_q, mem_cnt_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         pkt_cnt_q, pkt_cnt_d;
    state_e                state_q;
    logic                  rst_done_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic                  out_valid_q;

    logic [DATA_WIDTH:0] head;
    logic                wr_en;
    logic                wr_last;
    logic                rd_fire;
    logic                release_ok;
    logic                load;
    logic                ld_last;

    assign head    = mem_q[rd_ptr_q];
    assign wr_en   = input_tvalid && input_tready;
    assign wr_last = wr_en && input_tlast;
    assign rd_fire = out_valid_q && output_ready;

    // Packet mode holds words back until a whole packet (or a full FIFO) exists
    assign release_ok = !PACKET_MODE
                     || (pkt_cnt_q != '0)
                     || (state_q == FORCED);

    assign load    = (!out_valid_q || output_ready)
                  && (mem_cnt_q != '0)
                  && release_ok;
    assign ld_last = load && head[DATA_WIDTH];

    assign input_tready = rst_done_q && (count_q < DEPTH_C);
    assign output_data  = out_data_q;
    assign output_valid = out_valid_q;
    assign output_last  = out_last_q;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    always_comb begin
        count_d   = count_q;
        mem_cnt_d = mem_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_en && !rd_fire) begin
            count_d = count_q + ONE_C;
        end else if (!wr_en && rd_fire) begin
            count_d = count_q - ONE_C;
        end
        if (wr_en && !load) begin
            mem_cnt_d = mem_cnt_q + ONE_C;
        end else if (!wr_en && load) begin
            mem_cnt_d = mem_cnt_q - ONE_C;
        end
        if (wr_last && !ld_last) begin
            pkt_cnt_d = pkt_cnt_q + ONE_C;
        end else if (!wr_last && ld_last) begin
            pkt_cnt_d = pkt_cnt_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {input_tlast, input_tdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            count_q     <= '0;
            pkt_cnt_q   <= '0;
            state_q     <= GATED;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            count_q    <= count_d;
            mem_cnt_q  <= mem_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PONE_C;
            end
            if (load) begin
                rd_ptr_q    <= rd_ptr_q + PONE_C;
                out_data_q  <= head[DATA_WIDTH-1:0];
                out_last_q  <= head[DATA_WIDTH];
                out_valid_q <= 1'b1;
            end else if (rd_fire) begin
                out_valid_q <= 1'b0;
            end
            // FORCED lets an oversized packet drain instead of deadlocking
            unique case (state_q)
                GATED: begin
                    if (PACKET_MODE && (count_q == DEPTH_C)
                        && (pkt_cnt_q == '0)) begin
                        state_q <= FORCED;
                    end
                end
                FORCED: begin
                    if (ld_last) begin
                        state_q <= GATED;
                    end
                end
            endcase
        end
    end
endmodule
